// File: rtl/cache_tag_resolver.sv
// cache_tag_resolver
// Lookup controller for a 4-way set-associative cache. Each line request
// resolves to a hit way or a miss. A miss picks a victim, issues a
// fill/evict request to the DRAM controller and writes the new tag once the
// line has landed. Every completed access updates the cache_LRU entry for
// its set.
module cache_tag_resolver #(
   parameter int SET_BITS = 9,
   parameter int TAG_BITS = 16
) (
   input  logic                         main_clk,
   input  logic                         rst,

   input  logic                         req_valid,
   input  logic [TAG_BITS+SET_BITS-1:0] req_addr,
   output logic                         req_ready,

   output logic                         resp_valid,
   output logic                         resp_hit,
   output logic [1:0]                   resp_way,

   output logic [SET_BITS-1:0]          lru_addr,
   output logic [1:0]                   lru_used_index,
   output logic                         lru_enable_write,
   input  logic [1:0]                   lru_least_used_index,

   output logic [SET_BITS-1:0]          tag_rd_addr,
   input  logic [4*(TAG_BITS+1)-1:0]    tag_rd_data,
   output logic                         tag_wr_en,
   output logic [1:0]                   tag_wr_way,
   output logic [SET_BITS-1:0]          tag_wr_addr,
   output logic [TAG_BITS:0]            tag_wr_data,

   output logic                         fill_req_valid,
   input  logic                         fill_req_ready,
   output logic [TAG_BITS+SET_BITS-1:0] fill_addr,
   output logic [1:0]                   fill_way,
   output logic                         fill_evict_valid,
   output logic [TAG_BITS-1:0]          fill_evict_tag,
   input  logic                         fill_done
);

   localparam int ENTRY_BITS = TAG_BITS + 1;
   localparam int ADDR_BITS  = TAG_BITS + SET_BITS;

   // state     | meaning
   // IDLE      | ready; tag RAM and LRU read addresses follow req_addr
   // LOOKUP    | tag row and LRU victim are valid; resolve hit or pick victim
   // FILL_REQ  | fill/evict request held stable until the DRAM side accepts
   // FILL_WAIT | waiting for the line to be written into the victim way
   // RESP      | one-cycle response, LRU update, tag write on a miss
   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] LOOKUP    = 3'd1;
   localparam logic [2:0] FILL_REQ  = 3'd2;
   localparam logic [2:0] FILL_WAIT = 3'd3;
   localparam logic [2:0] RESP      = 3'd4;

   logic [2:0]          state;
   logic [2:0]          state_nxt;
   logic                accept;

   logic [SET_BITS-1:0] set_q;
   logic [TAG_BITS-1:0] tag_q;
   logic [1:0]          way_q;

   logic [3:0]          way_valid;
   logic [TAG_BITS-1:0] way_tag [4];
   logic                hit_found;
   logic [1:0]          hit_way;
   logic                inv_found;
   logic [1:0]          inv_way;
   logic [1:0]          victim_way;

   assign accept = (state == IDLE) && req_valid;

   // Handshake and read addresses: combinational only in IDLE so the
   // RAM/LRU read issued on the accept edge belongs to the new request.
   // Later states present the latched set; reset forces everything low.
   assign req_ready   = (state == IDLE) && !rst;
   assign lru_addr    = (state == IDLE) ? (rst ? '0 : req_addr[SET_BITS-1:0]) : set_q;
   assign tag_rd_addr = (state == IDLE) ? (rst ? '0 : req_addr[SET_BITS-1:0]) : set_q;

   // Split the tag RAM row into per-way valid bits and tags.
   always_comb begin
      for (int w = 0; w < 4; w++) begin
         way_valid[w] = tag_rd_data[w*ENTRY_BITS + TAG_BITS];
         way_tag[w]   = tag_rd_data[w*ENTRY_BITS +: TAG_BITS];
      end
   end

   // Hit detection; scanning downward leaves the lowest matching way.
   always_comb begin
      hit_found = 1'b0;
      hit_way   = 2'd0;
      for (int w = 3; w >= 0; w--) begin
         if (way_valid[w] && (way_tag[w] == tag_q)) begin
            hit_found = 1'b1;
            hit_way   = 2'(w);
         end
      end
   end

   // Victim choice: an empty way is always preferred over evicting a line,
   // the LRU only arbitrates between four valid ways.
   always_comb begin
      inv_found = 1'b0;
      inv_way   = 2'd0;
      for (int w = 3; w >= 0; w--) begin
         if (!way_valid[w]) begin
            inv_found = 1'b1;
            inv_way   = 2'(w);
         end
      end
      victim_way = inv_found ? inv_way : lru_least_used_index;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (req_valid) state_nxt = LOOKUP;
         LOOKUP:    state_nxt = hit_found ? RESP : FILL_REQ;
         FILL_REQ:  if (fill_req_ready) state_nxt = FILL_WAIT;
         FILL_WAIT: if (fill_done) state_nxt = RESP;
         RESP:      state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge main_clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Latch the accepted line address for the rest of the access.
   always_ff @(posedge main_clk or posedge rst) begin
      if (rst) begin
         set_q <= '0;
         tag_q <= '0;
      end else if (accept) begin
         set_q <= req_addr[SET_BITS-1:0];
         tag_q <= req_addr[ADDR_BITS-1:SET_BITS];
      end
   end

   // Remember the victim across the fill; fill_way is cleared on acceptance.
   always_ff @(posedge main_clk or posedge rst) begin
      if (rst)                                way_q <= 2'd0;
      else if ((state == LOOKUP) && !hit_found) way_q <= victim_way;
   end

   // Fill request registers: loaded on a miss, held until accepted.
   always_ff @(posedge main_clk or posedge rst) begin
      if (rst) begin
         fill_req_valid   <= 1'b0;
         fill_addr        <= '0;
         fill_way         <= 2'd0;
         fill_evict_valid <= 1'b0;
         fill_evict_tag   <= '0;
      end else if ((state == LOOKUP) && !hit_found) begin
         fill_req_valid   <= 1'b1;
         fill_addr        <= {tag_q, set_q};
         fill_way         <= victim_way;
         fill_evict_valid <= way_valid[victim_way];
         fill_evict_tag   <= way_tag[victim_way];
      end else if ((state == FILL_REQ) && fill_req_ready) begin
         fill_req_valid   <= 1'b0;
         fill_addr        <= '0;
         fill_way         <= 2'd0;
         fill_evict_valid <= 1'b0;
         fill_evict_tag   <= '0;
      end
   end

   // Response, LRU update and tag write: all loaded on the edge entering
   // RESP so they are high for exactly the RESP cycle.
   always_ff @(posedge main_clk or posedge rst) begin
      if (rst) begin
         resp_valid       <= 1'b0;
         resp_hit         <= 1'b0;
         resp_way         <= 2'd0;
         lru_used_index   <= 2'd0;
         lru_enable_write <= 1'b0;
         tag_wr_en        <= 1'b0;
         tag_wr_way       <= 2'd0;
         tag_wr_addr      <= '0;
         tag_wr_data      <= '0;
      end else begin
         resp_valid       <= 1'b0;
         resp_hit         <= 1'b0;
         resp_way         <= 2'd0;
         lru_used_index   <= 2'd0;
         lru_enable_write <= 1'b0;
         tag_wr_en        <= 1'b0;
         tag_wr_way       <= 2'd0;
         tag_wr_addr      <= '0;
         tag_wr_data      <= '0;
         if ((state == LOOKUP) && hit_found) begin
            resp_valid       <= 1'b1;
            resp_hit         <= 1'b1;
            resp_way         <= hit_way;
            lru_used_index   <= hit_way;
            lru_enable_write <= 1'b1;
         end else if ((state == FILL_WAIT) && fill_done) begin
            resp_valid       <= 1'b1;
            resp_way         <= way_q;
            lru_used_index   <= way_q;
            lru_enable_write <= 1'b1;
            tag_wr_en        <= 1'b1;
            tag_wr_way       <= way_q;
            tag_wr_addr      <= set_q;
            tag_wr_data      <= {1'b1, tag_q};
         end
      end
   end

endmodule

// File: tb/tb_cache_tag_resolver.sv
// Bench for cache_tag_resolver: behavioural tag RAM and LRU (timestamp based)
// around the DUT, directed scenarios plus randomized traffic.
module tb_cache_tag_resolver;
   localparam int SB = 9;
   localparam int TB = 16;
   localparam int AB = SB + TB;

   logic              main_clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic [AB-1:0]     req_addr = '0;
   logic              req_ready;
   logic              resp_valid, resp_hit;
   logic [1:0]        resp_way;
   logic [SB-1:0]     lru_addr;
   logic [1:0]        lru_used_index;
   logic              lru_enable_write;
   logic [1:0]        lru_least_used_index;
   logic [SB-1:0]     tag_rd_addr;
   logic [4*(TB+1)-1:0] tag_rd_data;
   logic              tag_wr_en;
   logic [1:0]        tag_wr_way;
   logic [SB-1:0]     tag_wr_addr;
   logic [TB:0]       tag_wr_data;
   logic              fill_req_valid;
   logic              fill_req_ready = 1'b0;
   logic [AB-1:0]     fill_addr;
   logic [1:0]        fill_way;
   logic              fill_evict_valid;
   logic [TB-1:0]     fill_evict_tag;
   logic              fill_done = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   cache_tag_resolver #(.SET_BITS(SB), .TAG_BITS(TB)) dut (
      .main_clk(main_clk), .rst(rst),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
      .lru_addr(lru_addr), .lru_used_index(lru_used_index),
      .lru_enable_write(lru_enable_write), .lru_least_used_index(lru_least_used_index),
      .tag_rd_addr(tag_rd_addr), .tag_rd_data(tag_rd_data),
      .tag_wr_en(tag_wr_en), .tag_wr_way(tag_wr_way), .tag_wr_addr(tag_wr_addr),
      .tag_wr_data(tag_wr_data),
      .fill_req_valid(fill_req_valid), .fill_req_ready(fill_req_ready),
      .fill_addr(fill_addr), .fill_way(fill_way), .fill_evict_valid(fill_evict_valid),
      .fill_evict_tag(fill_evict_tag), .fill_done(fill_done)
   );

   always #5 main_clk = ~main_clk;

   // Tag RAM model: 1-cycle read, write port from DUT, preload port from bench.
   bit [TB:0]     tagm [512][4];
   logic          pl_en = 1'b0;
   logic [SB-1:0] pl_set = '0;
   logic [1:0]    pl_way = '0;
   logic [TB:0]   pl_data = '0;

   always @(posedge main_clk) begin
      for (int w = 0; w < 4; w++) tag_rd_data[w*(TB+1) +: TB+1] <= tagm[tag_rd_addr][w];
      if (tag_wr_en) tagm[tag_wr_addr][tag_wr_way] <= tag_wr_data;
      if (pl_en) tagm[pl_set][pl_way] <= pl_data;
   end

   // LRU model: each way carries the time of its last use; least recently
   // used is the smallest stamp, ties go to the highest way index.
   int unsigned stamp [512][4];
   int unsigned now_t = 0;

   function automatic logic [1:0] least_fwd(input logic [SB-1:0] s, input bit we, input logic [1:0] used);
      int unsigned best;
      int unsigned v;
      logic [1:0]  bw;
      best = 32'hFFFF_FFFF;
      bw   = 2'd3;
      for (int w = 3; w >= 0; w--) begin
         v = (we && used == 2'(w)) ? 32'hFFFF_FFFF : stamp[s][w];
         if (w == 3 || v < best) begin
            best = v;
            bw   = 2'(w);
         end
      end
      return bw;
   endfunction

   always @(posedge main_clk) begin
      if (lru_enable_write) begin
         stamp[lru_addr][lru_used_index] <= now_t + 1;
         now_t <= now_t + 1;
      end
      lru_least_used_index <= least_fwd(lru_addr, lru_enable_write, lru_used_index);
   end

   // Values captured during the last transaction for scenario checks.
   logic          c_hit, c_lru_we, c_ev_valid;
   logic [1:0]    c_resp_way, c_lru_idx, c_fill_way;
   logic [TB-1:0] c_ev_tag;
   logic [TB:0]   c_wr_data;

   task automatic preload(input logic [SB-1:0] s, input logic [1:0] w, input logic [TB:0] d);
      pl_en = 1'b1; pl_set = s; pl_way = w; pl_data = d;
      @(negedge main_clk);
      pl_en = 1'b0;
   endtask

   // One complete access, called and returning at a negedge with the DUT idle.
   task automatic txn(input logic [AB-1:0] addr, input int stall, input bit done_in_stall);
      logic [SB-1:0] s;
      logic [TB-1:0] t;
      bit            e_hit;
      logic [1:0]    e_way;
      logic          e_evv;
      logic [TB-1:0] e_evt;
      int            wait_n;
      s = addr[SB-1:0];
      t = addr[AB-1:SB];
      e_hit = 1'b0;
      e_way = 2'd0;
      for (int w = 3; w >= 0; w--)
         if (tagm[s][w][TB] && tagm[s][w][TB-1:0] == t) begin e_hit = 1'b1; e_way = 2'(w); end
      if (!e_hit) begin
         e_way = least_fwd(s, 1'b0, 2'd0);
         for (int w = 3; w >= 0; w--) if (!tagm[s][w][TB]) e_way = 2'(w);
      end
      e_evv = tagm[s][e_way][TB];
      e_evt = tagm[s][e_way][TB-1:0];

      req_valid = 1'b1; req_addr = addr;
      #1;
      n_checks++;
      if ({req_ready, lru_addr, tag_rd_addr, lru_enable_write} !== {1'b1, s, s, 1'b0}) begin
         n_errors++;
         $display("FAIL idle_ready addr=%h got rdy=%b lru=%h tag=%h we=%b want set=%h", addr, req_ready, lru_addr, tag_rd_addr, lru_enable_write, s);
      end
      @(negedge main_clk);
      req_valid = 1'b0;
      n_checks++;
      if ({req_ready, resp_valid, fill_req_valid} !== 3'b000) begin
         n_errors++;
         $display("FAIL lookup_quiet addr=%h got rdy=%b resp=%b fill=%b want 000", addr, req_ready, resp_valid, fill_req_valid);
      end
      @(negedge main_clk);
      if (e_hit) begin
         n_checks++;
         if ({resp_valid, resp_hit, resp_way, lru_enable_write, lru_used_index, lru_addr, tag_wr_en, fill_req_valid, req_ready}
             !== {1'b1, 1'b1, e_way, 1'b1, e_way, s, 1'b0, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL hit_resp addr=%h got v=%b hit=%b way=%0d lwe=%b lidx=%0d laddr=%h twe=%b fill=%b rdy=%b want way=%0d", addr,
                     resp_valid, resp_hit, resp_way, lru_enable_write, lru_used_index, lru_addr, tag_wr_en, fill_req_valid, req_ready, e_way);
         end
         c_hit = resp_hit; c_resp_way = resp_way; c_lru_idx = lru_used_index; c_lru_we = lru_enable_write;
      end else begin
         n_checks++;
         if ({fill_req_valid, fill_addr, fill_way, resp_valid} !== {1'b1, addr, e_way, 1'b0}) begin
            n_errors++;
            $display("FAIL fill_req addr=%h got v=%b faddr=%h fway=%0d resp=%b want way=%0d", addr, fill_req_valid, fill_addr, fill_way, resp_valid, e_way);
         end
         n_checks++;
         if (fill_evict_valid !== e_evv || (e_evv && fill_evict_tag !== e_evt)) begin
            n_errors++;
            $display("FAIL fill_evict addr=%h got ev=%b tag=%h want ev=%b tag=%h", addr, fill_evict_valid, fill_evict_tag, e_evv, e_evt);
         end
         c_fill_way = fill_way; c_ev_valid = fill_evict_valid; c_ev_tag = fill_evict_tag;
         for (int k = 0; k < stall; k++) begin
            fill_req_ready = 1'b0;
            fill_done = done_in_stall && (k == stall / 2);
            @(negedge main_clk);
            fill_done = 1'b0;
            n_checks++;
            if ({fill_req_valid, fill_addr, fill_way, fill_evict_valid, fill_evict_tag, resp_valid}
                !== {1'b1, addr, c_fill_way, c_ev_valid, c_ev_tag, 1'b0}) begin
               n_errors++;
               $display("FAIL fill_stall k=%0d got v=%b faddr=%h fway=%0d ev=%b etag=%h resp=%b want faddr=%h fway=%0d", k,
                        fill_req_valid, fill_addr, fill_way, fill_evict_valid, fill_evict_tag, resp_valid, addr, c_fill_way);
            end
         end
         fill_req_ready = 1'b1;
         @(negedge main_clk);
         fill_req_ready = 1'b0;
         n_checks++;
         if ({fill_req_valid, resp_valid} !== 2'b00) begin
            n_errors++;
            $display("FAIL fill_accept got fill=%b resp=%b want 00", fill_req_valid, resp_valid);
         end
         wait_n = int'($urandom_range(0, 2));
         for (int k = 0; k < wait_n; k++) begin
            @(negedge main_clk);
            n_checks++;
            if (resp_valid !== 1'b0) begin
               n_errors++;
               $display("FAIL fill_wait_early got resp=%b want 0", resp_valid);
            end
         end
         fill_done = 1'b1;
         @(negedge main_clk);
         fill_done = 1'b0;
         n_checks++;
         if ({resp_valid, resp_hit, resp_way, lru_enable_write, lru_used_index, lru_addr, tag_wr_en, tag_wr_way, tag_wr_addr, tag_wr_data, req_ready}
             !== {1'b1, 1'b0, e_way, 1'b1, e_way, s, 1'b1, e_way, s, {1'b1, t}, 1'b0}) begin
            n_errors++;
            $display("FAIL miss_resp addr=%h got v=%b hit=%b way=%0d lwe=%b lidx=%0d laddr=%h twe=%b tway=%0d taddr=%h tdata=%h rdy=%b want way=%0d", addr,
                     resp_valid, resp_hit, resp_way, lru_enable_write, lru_used_index, lru_addr, tag_wr_en, tag_wr_way, tag_wr_addr, tag_wr_data, req_ready, e_way);
         end
         c_hit = resp_hit; c_resp_way = resp_way; c_lru_idx = lru_used_index; c_lru_we = lru_enable_write; c_wr_data = tag_wr_data;
      end
      @(negedge main_clk);
      n_checks++;
      if ({req_ready, resp_valid, lru_enable_write, tag_wr_en, fill_req_valid} !== 5'b10000) begin
         n_errors++;
         $display("FAIL back_idle got rdy=%b resp=%b lwe=%b twe=%b fill=%b want 10000", req_ready, resp_valid, lru_enable_write, tag_wr_en, fill_req_valid);
      end
      if (!e_hit) begin
         n_checks++;
         if (tagm[s][e_way] !== {1'b1, t}) begin
            n_errors++;
            $display("FAIL tag_ram_written set=%h way=%0d got %h want %h", s, e_way, tagm[s][e_way], {1'b1, t});
         end
      end
   endtask

   task automatic test_reset;
      req_addr = {16'h5A5A, 9'h155};
      #1;
      n_checks++;
      if ({req_ready, lru_addr, tag_rd_addr} !== '0) begin
         n_errors++;
         $display("FAIL reset_inputs_gated got rdy=%b lru=%h tag=%h want 0", req_ready, lru_addr, tag_rd_addr);
      end
      repeat (2) @(negedge main_clk);
      req_addr = '0;
      rst = 1'b0;
      #1;
      n_checks++;
      if ({req_ready, resp_valid, resp_hit, resp_way, lru_addr, lru_used_index, lru_enable_write, tag_rd_addr, tag_wr_en, tag_wr_way,
           tag_wr_addr, tag_wr_data, fill_req_valid, fill_addr, fill_way, fill_evict_valid, fill_evict_tag} !== {1'b1, {(4+2*SB+2+1+1+2+SB+TB+1+1+AB+2+1+TB){1'b0}}}) begin
         n_errors++;
         $display("FAIL reset_release got rdy=%b resp=%b fill=%b lwe=%b twe=%b want only ready", req_ready, resp_valid, fill_req_valid, lru_enable_write, tag_wr_en);
      end
      @(negedge main_clk);
   endtask

   task automatic test_cold_miss;
      txn({16'h1234, 9'h005}, 0, 1'b0);
      n_checks++;
      if ({c_fill_way, c_ev_valid, c_hit, c_resp_way, c_wr_data, c_lru_idx, c_lru_we} !== {2'd0, 1'b0, 1'b0, 2'd0, 17'h1_1234, 2'd0, 1'b1}) begin
         n_errors++;
         $display("FAIL cold_miss got fway=%0d ev=%b hit=%b way=%0d wdata=%h lidx=%0d lwe=%b", c_fill_way, c_ev_valid, c_hit, c_resp_way, c_wr_data, c_lru_idx, c_lru_we);
      end
   endtask

   task automatic test_hit;
      preload(9'h005, 2'd2, {1'b1, 16'hABCD});
      txn({16'hABCD, 9'h005}, 0, 1'b0);
      n_checks++;
      if ({c_hit, c_resp_way} !== {1'b1, 2'd2}) begin
         n_errors++;
         $display("FAIL hit_way2 got hit=%b way=%0d want hit=1 way=2", c_hit, c_resp_way);
      end
   endtask

   task automatic test_full_evict;
      preload(9'h0FF, 2'd0, {1'b1, 16'h0011});
      preload(9'h0FF, 2'd1, {1'b1, 16'h0022});
      preload(9'h0FF, 2'd2, {1'b1, 16'h0033});
      preload(9'h0FF, 2'd3, {1'b1, 16'h0042});
      txn({16'h7777, 9'h0FF}, 1, 1'b0);
      n_checks++;
      if ({c_fill_way, c_ev_valid, c_ev_tag} !== {2'd3, 1'b1, 16'h0042}) begin
         n_errors++;
         $display("FAIL full_evict got fway=%0d ev=%b etag=%h want 3 1 0042", c_fill_way, c_ev_valid, c_ev_tag);
      end
   endtask

   task automatic test_fill_stall;
      txn({16'h0BEE, 9'h033}, 5, 1'b1);
      n_checks++;
      if ({c_hit, c_resp_way, c_fill_way} !== {1'b0, 2'd0, 2'd0}) begin
         n_errors++;
         $display("FAIL fill_stall_resp got hit=%b way=%0d fway=%0d want 0 0 0", c_hit, c_resp_way, c_fill_way);
      end
   endtask

   task automatic test_back_to_back;
      preload(9'h010, 2'd0, {1'b1, 16'h0A00});
      preload(9'h010, 2'd1, {1'b1, 16'h0B11});
      preload(9'h010, 2'd2, {1'b1, 16'h0C22});
      preload(9'h010, 2'd3, {1'b1, 16'h0D33});
      txn({16'h0D33, 9'h010}, 0, 1'b0);
      txn({16'h0C22, 9'h010}, 0, 1'b0);
      txn({16'h0B11, 9'h010}, 0, 1'b0);
      n_checks++;
      if (c_resp_way !== 2'd1) begin
         n_errors++;
         $display("FAIL b2b_first got way=%0d want 1", c_resp_way);
      end
      txn({16'h0A00, 9'h010}, 0, 1'b0);
      n_checks++;
      if (c_resp_way !== 2'd0) begin
         n_errors++;
         $display("FAIL b2b_second got way=%0d want 0", c_resp_way);
      end
      // Use order is now 3,2,1,0 (oldest first), so a miss must replace way 3.
      txn({16'hEEEE, 9'h010}, 0, 1'b0);
      n_checks++;
      if ({c_fill_way, c_ev_valid, c_ev_tag} !== {2'd3, 1'b1, 16'h0D33}) begin
         n_errors++;
         $display("FAIL b2b_lru_victim got fway=%0d ev=%b etag=%h want 3 1 0d33", c_fill_way, c_ev_valid, c_ev_tag);
      end
   endtask

   task automatic test_random;
      logic [SB-1:0] sp [3];
      logic [TB-1:0] t;
      sp[0] = 9'h020; sp[1] = 9'h021; sp[2] = 9'h1FF;
      for (int i = 0; i < 40; i++) begin
         t = 16'h3000 + 16'($urandom_range(0, 5));
         txn({t, sp[$urandom_range(0, 2)]}, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_reset_mid_fill;
      req_valid = 1'b1; req_addr = {16'h0F0F, 9'h1AA};
      @(negedge main_clk);
      req_valid = 1'b0;
      @(negedge main_clk);
      n_checks++;
      if (fill_req_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL rst_pre_fill got fill=%b want 1", fill_req_valid);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({fill_req_valid, req_ready, fill_addr, resp_valid} !== '0) begin
         n_errors++;
         $display("FAIL rst_drops_fill got fill=%b rdy=%b faddr=%h resp=%b want 0", fill_req_valid, req_ready, fill_addr, resp_valid);
      end
      test_reset();
      // Nothing was written by the aborted miss, so the set is still empty.
      txn({16'h0F0F, 9'h1AA}, 0, 1'b0);
      n_checks++;
      if ({c_fill_way, c_ev_valid} !== {2'd0, 1'b0}) begin
         n_errors++;
         $display("FAIL rst_retry got fway=%0d ev=%b want 0 0", c_fill_way, c_ev_valid);
      end
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_hit();
      test_full_evict();
      test_fill_stall();
      test_back_to_back();
      test_random();
      test_reset_mid_fill();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
